// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: state encoding and default job geometry for the CPU run controller.
package cpu_run_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        RUN,
        READ,
        DONE,
        ERR
    } run_state_t;

    localparam int DEF_NUM_OPS  = 7;
    localparam int DEF_RES_BASE = 10;
    localparam int DEF_NUM_RES  = 4;
    localparam int DEF_TIMEOUT  = 1024;

endpackage

// File: rtl/cpu_run_if.sv
// cpu_run_if: host/CPU/data-memory signal bundle around the run controller.
//   master : the controller (drives handshakes, DM port, results, status)
//   slave  : the environment (host streams, CPU, data memory)
interface cpu_run_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              go;
    logic              op_valid;
    logic [DATA_W-1:0] op_data;
    logic              op_ready;
    logic              dm_own;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              cpu_start;
    logic              cpu_ack;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              busy;
    logic              done;
    logic              timeout_err;

    modport master (
        input  go, op_valid, op_data, dm_rdata, cpu_ack,
        output op_ready, dm_own, dm_we, dm_addr, dm_wdata, cpu_start,
               res_valid, res_data, busy, done, timeout_err
    );

    modport slave (
        output go, op_valid, op_data, dm_rdata, cpu_ack,
        input  op_ready, dm_own, dm_we, dm_addr, dm_wdata, cpu_start,
               res_valid, res_data, busy, done, timeout_err
    );
endinterface

// File: rtl/run_timer.sv
// run_timer: RUN-phase watchdog counter.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : restart the count from zero
//   enable     : count one RUN cycle
//   expired    : count has reached TIMEOUT-1
module run_timer #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);

    logic [W-1:0] t_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       t_q <= '0;
        else if (clear)  t_q <= '0;
        else if (enable) t_q <= t_q + 1'b1;
    end

    assign expired = t_q == W'(TIMEOUT - 1);
endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: sequences one CPU job - operand preload, launch, supervised run, result readback.
//   clk, reset   : clock, asynchronous active-high reset
//   bus (master) : go request, operand stream, DM port + mux select, CPU start/ack,
//                  result stream, busy/done/timeout_err status
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int NUM_OPS  = DEF_NUM_OPS,
    parameter int RES_BASE = DEF_RES_BASE,
    parameter int NUM_RES  = DEF_NUM_RES,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input logic       clk,
    input logic       reset,
    cpu_run_if.master bus
);
    if (NUM_OPS > RES_BASE || RES_BASE + NUM_RES > 2 ** ADDR_W) begin : g_bad_cfg
        $fatal(1, "cpu_run_ctrl: result block overlaps operands or exceeds the DM address space");
    end

    localparam logic [ADDR_W-1:0] LAST_OP  = ADDR_W'(NUM_OPS - 1);
    localparam logic [ADDR_W-1:0] LAST_RES = ADDR_W'(NUM_RES - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(RES_BASE);

    run_state_t        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ack_low_q, cpu_start_q, dm_own_q, res_valid_q, done_q, err_q;
    logic              wr, ack_ok, expired;

    assign wr     = state_q == LOAD && bus.op_valid;
    // an ack only counts after it has been seen low in this run, so a stale one is rejected
    assign ack_ok = state_q == RUN && ack_low_q && bus.cpu_ack;

    run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_q == START),
        .enable (state_q == RUN),
        .expired(expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ack_low_q   <= 1'b0;
            cpu_start_q <= 1'b0;
            dm_own_q    <= 1'b1;
            res_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            res_valid_q <= state_q == READ;
            case (state_q)
                IDLE: if (bus.go) begin
                    state_q <= LOAD;
                    cnt_q   <= '0;
                    err_q   <= 1'b0;
                end
                LOAD: if (bus.op_valid) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_OP) begin
                        state_q     <= START;
                        cpu_start_q <= 1'b1;
                        dm_own_q    <= 1'b0;
                    end
                end
                START: begin
                    state_q   <= RUN;
                    ack_low_q <= 1'b0;
                end
                RUN: begin
                    if (!bus.cpu_ack) ack_low_q <= 1'b1;
                    if (ack_ok) begin
                        state_q  <= READ;
                        cnt_q    <= '0;
                        dm_own_q <= 1'b1;
                    end else if (expired) begin
                        state_q <= ERR;
                    end
                end
                READ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_RES) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                ERR: begin
                    state_q  <= IDLE;
                    err_q    <= 1'b1;
                    dm_own_q <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.op_ready    = state_q == LOAD;
    assign bus.dm_own      = dm_own_q;
    assign bus.dm_we       = wr;
    assign bus.dm_addr     = wr ? cnt_q : state_q == READ ? BASE + cnt_q : '0;
    assign bus.dm_wdata    = wr ? bus.op_data : {DATA_W{1'b0}};
    assign bus.cpu_start   = cpu_start_q;
    // the synchronous DM returns data in the cycle after the address, aligned with res_valid
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_valid_q ? bus.dm_rdata : {DATA_W{1'b0}};
    assign bus.busy        = state_q != IDLE;
    assign bus.done        = done_q;
    assign bus.timeout_err = err_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: scoreboard bench for cpu_run_ctrl with a DM model and a scripted CPU.
module tb_cpu_run_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       clr = 1'b0;
    int         tests = 0, failed = 0, cyc = 0, done_cnt = 0, done_cyc = 0, t_bad = 0;
    int         exp_q[$];
    int         ops [7] = '{25, 45, 14, 9, 27, 30, 3};
    int         res [4] = '{70, 5, 253, 15};
    logic [7:0] mem [256];

    cpu_run_if #(.ADDR_W(8), .DATA_W(8)) b ();
    cpu_run_if #(.ADDR_W(8), .DATA_W(8)) t ();

    cpu_run_ctrl u_dut (.clk(clk), .reset(reset), .bus(b));
    cpu_run_ctrl #(.TIMEOUT(16)) u_to (.clk(clk), .reset(reset), .bus(t));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // data memory: operands land in mem, the CPU's result block sits at 10..13
    always @(posedge clk) begin
        if (clr) foreach (mem[i]) mem[i] <= 8'd0;
        else if (b.dm_we) mem[b.dm_addr] <= b.dm_wdata;
        b.dm_rdata <= (b.dm_addr >= 8'd10 && b.dm_addr <= 8'd13) ? 8'(res[2'(b.dm_addr - 8'd10)]) : mem[b.dm_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) if (!reset) begin
        if (b.res_valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                failed++;
                $display("FAIL res_extra: got res_data %0d with no result expected", b.res_data);
            end else chk("res_data", int'(b.res_data), exp_q.pop_front());
        end
        if (b.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_last_res", int'(b.res_valid), 1);
            chk("done_res_left", exp_q.size(), 0);
            chk("done_err", int'(b.timeout_err), 0);
        end
        if (b.dm_we) begin
            chk("we_op_valid", int'(b.op_valid), 1);
            chk("we_dm_own", int'(b.dm_own), 1);
        end
        if (t.res_valid || t.done) t_bad++;
    end

    task automatic job(input int stall, input int stale, input int igo, input int lat);
        int g, d0, ack_at;
        ack_at = stale != 0 ? 12 : 20;
        foreach (res[i]) exp_q.push_back(res[i]);
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        b.cpu_ack = stale != 0;
        b.go = 1'b1;
        g = cyc;
        d0 = done_cnt;
        @(posedge clk); #1 b.go = 1'b0;
        chk("load_ready", int'(b.op_ready), 1);
        for (int i = 0; i < 7; i++) begin
            if (stall != 0 && i == 2) begin
                b.op_valid = 1'b0;
                repeat (3) @(posedge clk);
                #1;
            end
            b.op_valid = 1'b1;
            b.op_data = 8'(ops[i]);
            b.go = igo != 0 && i == 3;
            @(posedge clk); #1;
        end
        b.op_valid = 1'b0;
        b.go = 1'b0;
        chk("start_pulse", int'(b.cpu_start), 1);
        chk("start_own", int'(b.dm_own), 0);
        for (int k = 1; k <= ack_at; k++) begin
            @(posedge clk); #1;
            if (k == 1) chk("start_once", int'(b.cpu_start), 0);
            if (stale != 0 && k == 6) b.cpu_ack = 1'b0;
            if (k == ack_at) b.cpu_ack = 1'b1;
        end
        if (igo != 0) begin
            @(posedge clk); #1 b.go = 1'b1;
            @(posedge clk); #1 b.go = 1'b0;
        end
        for (int k = 0; k < 200 && done_cnt == d0; k++) @(posedge clk);
        if (done_cnt == d0) begin
            tests++;
            failed++;
            $display("FAIL done_wait: no done within 200 cycles");
        end else chk("latency", done_cyc - g, lat);
        #1;
        for (int i = 0; i < 7; i++) chk($sformatf("dm_op%0d", i), int'(mem[i]), ops[i]);
        if (igo != 0) begin
            repeat (20) @(posedge clk);
            #1;
            chk("one_done", done_cnt - d0, 1);
            chk("igo_idle", int'(b.busy), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        b.go = 1'b0;
        b.op_valid = 1'b0;
        b.op_data = 8'd0;
        b.cpu_ack = 1'b0;
        t.go = 1'b0;
        t.op_valid = 1'b1;
        t.op_data = 8'hA5;
        t.cpu_ack = 1'b0;
        t.dm_rdata = 8'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", int'(b.busy), 0);
        chk("rst_own", int'(b.dm_own), 1);
        chk("rst_ready", int'(b.op_ready), 0);
        chk("rst_start", int'(b.cpu_start), 0);
        chk("rst_we", int'(b.dm_we), 0);
        chk("rst_res_valid", int'(b.res_valid), 0);
        chk("rst_done", int'(b.done), 0);
        chk("rst_err", int'(b.timeout_err), 0);

        job(0, 0, 0, 33);
        job(1, 0, 0, 36);
        job(0, 1, 0, 25);
        job(0, 0, 1, 33);

        b.cpu_ack = 1'b0;
        @(posedge clk); #1 b.go = 1'b1;
        @(posedge clk); #1 b.go = 1'b0;
        b.op_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            b.op_data = 8'(ops[i]);
            @(posedge clk); #1;
        end
        b.op_valid = 1'b0;
        repeat (4) @(posedge clk);
        #4;
        chk("mid_busy", int'(b.busy), 1);
        chk("mid_own", int'(b.dm_own), 0);
        reset = 1'b1;
        #1;
        chk("arst_busy", int'(b.busy), 0);
        chk("arst_start", int'(b.cpu_start), 0);
        chk("arst_own", int'(b.dm_own), 1);
        chk("arst_res_data", int'(b.res_data), 0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("arst_stays_idle", int'(b.busy), 0);
        job(0, 0, 0, 33);

        @(posedge clk); #1 t.go = 1'b1;
        @(posedge clk); #1 t.go = 1'b0;
        repeat (23) @(posedge clk);
        #1;
        chk("to_last_run_busy", int'(t.busy), 1);
        chk("to_last_run_err", int'(t.timeout_err), 0);
        chk("to_run_own", int'(t.dm_own), 0);
        @(posedge clk); #1 chk("to_err_busy", int'(t.busy), 1);
        @(posedge clk); #1;
        chk("to_err_set", int'(t.timeout_err), 1);
        chk("to_idle", int'(t.busy), 0);
        chk("to_own", int'(t.dm_own), 1);
        repeat (3) @(posedge clk);
        #1 chk("to_err_sticky", int'(t.timeout_err), 1);
        t.go = 1'b1;
        @(posedge clk); #1 t.go = 1'b0;
        chk("to_err_cleared", int'(t.timeout_err), 0);
        chk("to_reload_busy", int'(t.busy), 1);
        chk("to_no_result", t_bad, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
